act_bank_resp: RTL and testbench
================================

Name: act_bank_resp

Overview:
Responder side of the activation-buffer read interface. It holds four activation SRAM banks (0..3) and serves per-bank read requests (bceN/braddrN), returning brdataN/brvalidN after a fixed pipeline latency. It also exposes a loader write port that fills the banks. Banks 0/1 form ping-pong group 0 and banks 2/3 form group 1, matching the activation reader's low/high 64-bit halves.

Parameters:
DATA_W, 64, bank word width in bits
ADDR_W, 15, request address width; row index = braddr[14:3]
DEPTH, 4096, rows per bank
RD_LAT, 2, read latency in clock edges, legal range 1..4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
bce0..bce3  in  1 each  read request strobe, per bank
braddr0..braddr3  in  15 each  read address, per bank
brdata0..brdata3  out  64 each  read data
brvalid0..brvalid3  out  1 each  read data valid, one-cycle pulse per request
wr_en  in  1  loader write request
wr_bank  in  2  target bank for the write
wr_addr  in  12  target row for the write
wr_data  in  64  write data
wr_ready  out  1  write accepted this cycle (combinational)
err_cnt  out  16  address-error count (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): all brvalidN=0, brdataN=0, all read pipeline stages cleared, err_cnt=0. Memory contents are not reset.
- Reset mid-operation: in-flight reads are dropped and no brvalid is produced for them after reset release.
- Storage: 4 independent single-port arrays, DEPTH x DATA_W each.
- Read:
  - bceN high at edge k captures row = braddrN[14:3] and reads bank N.
  - brvalidN is high for exactly the cycle following edge k+RD_LAT-1; brdataN carries mem[N][row] in that cycle.
  - Back-to-back bce gives back-to-back brvalid with no bubbles. Throughput is 1 read per bank per cycle.
  - brdataN = 0 whenever brvalidN = 0.
- Read pipeline: per bank, an RD_LAT-deep shift of {valid, data}. Stage 0 is the registered array output. Later stages are plain registers.
- braddrN[2:0] is ignored for addressing. Rows >= DEPTH wrap modulo DEPTH (row[11:0] used directly when DEPTH=4096).
- Banks are fully independent: simultaneous bce on all four banks is legal.
- Write:
  - wr_ready = !(bce of bank wr_bank). Reads have priority over writes.
  - A write takes effect at the edge where wr_en && wr_ready.
  - When wr_ready=0, the loader holds wr_* stable and retries. No write is lost.
- Ordering:
  - A write accepted at edge k is visible to a read sampled at edge k+1 or later.
  - A read and a write to the same bank never occur at the same edge.
- No internal state machine beyond the pipelines. Ping-pong group selection belongs to the requester; this block serves any bank at any time.

Optional Feature:
Macro ACT_RD_ERR_EN.
- Defined:
  - err_cnt increments by the number of read strobes in a cycle (0..4) whose braddrN[2:0] != 0 or whose row >= DEPTH.
  - err_cnt saturates at 16'hFFFF and is cleared only by reset.
  - The offending reads are still served, using the wrapped row.
- Not defined: err_cnt is tied to 0 and no error-checking logic is built.

Test Plan:
1. Reset, then write bank0 row5 = 64'hA5A5_0000_0000_0005; bce0=1, braddr0=15'h0028 at edge 10 -> brvalid0=1 with brdata0=64'hA5A5_0000_0000_0005 in the cycle after edge 11 (RD_LAT=2); brvalid0=0 otherwise.
2. Fill bank2 and bank3 rows 0..31 with value=row; issue 32 consecutive reads to rows 0..31 on both banks -> 32 contiguous brvalid2/brvalid3 pulses, data 0..31 in order, no gaps.
3. Hold bce1=1 while wr_en=1, wr_bank=1 -> wr_ready=0 each such cycle; drop bce1 -> write lands on the next edge and a following read returns the new value.
4. Write row7 of bank0 at edge k, read row7 at edge k+1 -> new data returned; a write to bank3 in the same cycle as a bank0 read -> wr_ready=1.
5. Issue 2 reads on bank0, assert rst_n low before they return, release -> no brvalid0 after release; brdata0=0.
6. With ACT_RD_ERR_EN defined: reads braddr0=15'h0003 and braddr1=15'h0001 in the same cycle -> err_cnt=2 and both reads return row 0. Without the macro -> err_cnt stays 0.

Source files
------------

// File: rtl/act_bank_resp.sv
// Activation-buffer read responder: four independent banks with per-bank fixed-latency reads
// and a loader write port. Optional macro ACT_RD_ERR_EN enables the address-error counter.
module act_bank_resp #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bce0,
    input  logic              bce1,
    input  logic              bce2,
    input  logic              bce3,
    input  logic [ADDR_W-1:0] braddr0,
    input  logic [ADDR_W-1:0] braddr1,
    input  logic [ADDR_W-1:0] braddr2,
    input  logic [ADDR_W-1:0] braddr3,
    output logic [DATA_W-1:0] brdata0,
    output logic [DATA_W-1:0] brdata1,
    output logic [DATA_W-1:0] brdata2,
    output logic [DATA_W-1:0] brdata3,
    output logic              brvalid0,
    output logic              brvalid1,
    output logic              brvalid2,
    output logic              brvalid3,
    input  logic              wr_en,
    input  logic [1:0]        wr_bank,
    input  logic [11:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [15:0]       err_cnt
);

    localparam int NB    = 4;
    localparam int ROW_W = $clog2(DEPTH);

    logic [NB-1:0]     bce;
    logic [ADDR_W-1:0] braddr [NB];

    assign bce       = {bce3, bce2, bce1, bce0};
    assign braddr[0] = braddr0;
    assign braddr[1] = braddr1;
    assign braddr[2] = braddr2;
    assign braddr[3] = braddr3;

    logic [DATA_W-1:0] mem [NB][DEPTH];
    logic              wr_fire;

    // Reads win the bank's single port; the loader simply retries next cycle.
    assign wr_ready = !bce[wr_bank];
    assign wr_fire  = wr_en && wr_ready;

    // NOTE: the storage array has no reset; clearing it would forbid SRAM inference.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_addr[ROW_W-1:0]] <= wr_data;
        end
    end

    logic [RD_LAT-1:0] valid_q [NB];
    logic [RD_LAT-1:0] valid_d [NB];
    logic [DATA_W-1:0] data_q  [NB][RD_LAT];
    logic [DATA_W-1:0] data_d  [NB][RD_LAT];

    // Stage 0 is the registered array output; data is zeroed when idle so brdata is 0 off-valid.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            valid_d[b]    = '0;
            valid_d[b][0] = bce[b];
            data_d[b][0]  = bce[b] ? mem[b][braddr[b][3 +: ROW_W]] : '0;
            for (int s = 1; s < RD_LAT; s++) begin
                valid_d[b][s] = valid_q[b][s-1];
                data_d[b][s]  = data_q[b][s-1];
            end
        end
    end

    // NOTE: non-blocking assignments keep every stage sampling its predecessor's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) begin
                valid_q[b] <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    data_q[b][s] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                valid_q[b] <= valid_d[b];
                for (int s = 0; s < RD_LAT; s++) begin
                    data_q[b][s] <= data_d[b][s];
                end
            end
        end
    end

    assign brvalid0 = valid_q[0][RD_LAT-1];
    assign brvalid1 = valid_q[1][RD_LAT-1];
    assign brvalid2 = valid_q[2][RD_LAT-1];
    assign brvalid3 = valid_q[3][RD_LAT-1];
    assign brdata0  = data_q[0][RD_LAT-1];
    assign brdata1  = data_q[1][RD_LAT-1];
    assign brdata2  = data_q[2][RD_LAT-1];
    assign brdata3  = data_q[3][RD_LAT-1];

`ifdef ACT_RD_ERR_EN
    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;
    logic [2:0]  err_hits;
    logic [16:0] err_sum;

    // An access is an error if it is not word-aligned or its row lies beyond DEPTH.
    always_comb begin
        err_hits = '0;
        for (int b = 0; b < NB; b++) begin
            if (bce[b] && ((braddr[b][2:0] != 3'b000) ||
                           (32'(braddr[b][ADDR_W-1:3]) >= 32'(DEPTH)))) begin
                err_hits = err_hits + 3'd1;
            end
        end
        err_sum   = {1'b0, err_cnt_q} + 17'(err_hits);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_lsbs;

    assign err_cnt     = '0;
    assign unused_lsbs = ^{braddr[0][2:0], braddr[1][2:0], braddr[2][2:0], braddr[3][2:0]};
`endif

endmodule

// File: tb/tb_act_bank_resp.sv
// Directed self-checking bench for act_bank_resp at default parameters (RD_LAT=2).
// Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
module tb_act_bank_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  bce_i;
    logic [14:0] braddr_i [4];
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [11:0] wr_addr;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic [15:0] err_cnt;
    logic [3:0]  v;
    logic [63:0] d [4];

    int n_cmp = 0;
    int n_mis = 0;

`ifdef ACT_RD_ERR_EN
    localparam logic [15:0] EXP_ERR = 16'd2;
`else
    localparam logic [15:0] EXP_ERR = 16'd0;
`endif

    always #5 clk = ~clk;

    act_bank_resp dut (
        .clk(clk), .rst_n(rst_n),
        .bce0(bce_i[0]), .bce1(bce_i[1]), .bce2(bce_i[2]), .bce3(bce_i[3]),
        .braddr0(braddr_i[0]), .braddr1(braddr_i[1]),
        .braddr2(braddr_i[2]), .braddr3(braddr_i[3]),
        .brdata0(d[0]), .brdata1(d[1]), .brdata2(d[2]), .brdata3(d[3]),
        .brvalid0(v[0]), .brvalid1(v[1]), .brvalid2(v[2]), .brvalid3(v[3]),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .err_cnt(err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] b, input logic [11:0] a, input logic [63:0] x);
        wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = x;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bce_i = '0;
        for (int b = 0; b < 4; b++) braddr_i[b] = '0;
        wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (v !== 4'b0000) begin
            n_mis++; $display("FAIL reset_valid: got %b expected 0000", v);
        end
        n_cmp++;
        if ((d[0] | d[1] | d[2] | d[3]) !== 64'd0) begin
            n_mis++; $display("FAIL reset_data: got %h %h %h %h expected all 0", d[0], d[1], d[2], d[3]);
        end
        n_cmp++;
        if (err_cnt !== 16'd0) begin
            n_mis++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_mis++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        do_write(2'd0, 12'd5, 64'hA5A5_0000_0000_0005);
        bce_i[0] = 1'b1; braddr_i[0] = 15'h0028;
        tick();
        bce_i[0] = 1'b0;
        n_cmp++;
        if (v[0] !== 1'b0 || d[0] !== 64'd0) begin
            n_mis++; $display("FAIL single_early: got v=%b d=%h expected v=0 d=0", v[0], d[0]);
        end
        tick();
        n_cmp++;
        if (v[0] !== 1'b1 || d[0] !== 64'hA5A5_0000_0000_0005) begin
            n_mis++; $display("FAIL single_data: got v=%b d=%h expected v=1 d=a5a5000000000005", v[0], d[0]);
        end
        tick();
        n_cmp++;
        if (v[0] !== 1'b0 || d[0] !== 64'd0) begin
            n_mis++; $display("FAIL single_late: got v=%b d=%h expected v=0 d=0", v[0], d[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        logic [63:0] exp2, exp3;
        for (int r = 0; r < 32; r++) begin
            do_write(2'd2, 12'(r), 64'(r));
            do_write(2'd3, 12'(r), 64'(r) + 64'h300);
        end
        for (int t = 0; t < 34; t++) begin
            bce_i[2] = (t < 32);
            bce_i[3] = (t < 32);
            braddr_i[2] = 15'(t << 3);
            braddr_i[3] = 15'(t << 3);
            tick();
            exp_v = (t >= 1 && t <= 32);
            exp2  = exp_v ? 64'(t - 1) : 64'd0;
            exp3  = exp_v ? 64'(t - 1) + 64'h300 : 64'd0;
            n_cmp++;
            if (v[2] !== exp_v || v[3] !== exp_v || d[2] !== exp2 || d[3] !== exp3) begin
                n_mis++;
                $display("FAIL stream_t%0d: got v2=%b v3=%b d2=%h d3=%h expected v=%b d2=%h d3=%h",
                         t, v[2], v[3], d[2], d[3], exp_v, exp2, exp3);
            end
        end
        bce_i[2] = 1'b0; bce_i[3] = 1'b0;
    endtask

    task automatic test_read_priority();
        bce_i[1] = 1'b1; braddr_i[1] = 15'h0000;
        wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 12'd9; wr_data = 64'hDEAD_BEEF_0000_0009;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (wr_ready !== 1'b0) begin
                n_mis++; $display("FAIL stall_c%0d: got wr_ready=%b expected 0", c, wr_ready);
            end
            tick();
        end
        bce_i[1] = 1'b0;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_mis++; $display("FAIL stall_release: got wr_ready=%b expected 1", wr_ready);
        end
        tick();
        wr_en = 1'b0;
        bce_i[1] = 1'b1; braddr_i[1] = 15'(9 << 3);
        tick();
        bce_i[1] = 1'b0;
        tick();
        n_cmp++;
        if (v[1] !== 1'b1 || d[1] !== 64'hDEAD_BEEF_0000_0009) begin
            n_mis++; $display("FAIL stall_readback: got v=%b d=%h expected v=1 d=deadbeef00000009", v[1], d[1]);
        end
    endtask

    task automatic test_rd_after_wr();
        do_write(2'd0, 12'd7, 64'h0000_0000_0000_0001);
        wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 12'd7; wr_data = 64'h7777_0000_0000_0007;
        tick();
        wr_en = 1'b0;
        bce_i[0] = 1'b1; braddr_i[0] = 15'(7 << 3);
        tick();
        bce_i[0] = 1'b0;
        tick();
        n_cmp++;
        if (v[0] !== 1'b1 || d[0] !== 64'h7777_0000_0000_0007) begin
            n_mis++; $display("FAIL raw_next_edge: got v=%b d=%h expected v=1 d=7777000000000007", v[0], d[0]);
        end
        bce_i[0] = 1'b1; braddr_i[0] = 15'h0028;
        wr_en = 1'b1; wr_bank = 2'd3; wr_addr = 12'd40; wr_data = 64'hB3B3_0000_0000_0040;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_mis++; $display("FAIL cross_bank_ready: got wr_ready=%b expected 1", wr_ready);
        end
        tick();
        wr_en = 1'b0; bce_i[0] = 1'b0;
        tick();
        n_cmp++;
        if (v[0] !== 1'b1 || d[0] !== 64'hA5A5_0000_0000_0005) begin
            n_mis++; $display("FAIL cross_bank_read: got v=%b d=%h expected v=1 d=a5a5000000000005", v[0], d[0]);
        end
        bce_i[3] = 1'b1; braddr_i[3] = 15'(40 << 3);
        tick();
        bce_i[3] = 1'b0;
        tick();
        n_cmp++;
        if (v[3] !== 1'b1 || d[3] !== 64'hB3B3_0000_0000_0040) begin
            n_mis++; $display("FAIL cross_bank_write: got v=%b d=%h expected v=1 d=b3b3000000000040", v[3], d[3]);
        end
    endtask

    task automatic test_reset_mid();
        bce_i[0] = 1'b1; braddr_i[0] = 15'h0028;
        tick();
        #2 rst_n = 1'b0;
        tick();
        bce_i[0] = 1'b0;
        n_cmp++;
        if (v[0] !== 1'b0 || d[0] !== 64'd0) begin
            n_mis++; $display("FAIL midreset_hold: got v=%b d=%h expected v=0 d=0", v[0], d[0]);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (v[0] !== 1'b0 || d[0] !== 64'd0) begin
                n_mis++; $display("FAIL midreset_c%0d: got v=%b d=%h expected v=0 d=0", c, v[0], d[0]);
            end
        end
    endtask

    task automatic test_addr_err();
        do_write(2'd0, 12'd0, 64'h0000_0000_0000_00A0);
        do_write(2'd1, 12'd0, 64'h1111_0000_0000_0000);
        bce_i[0] = 1'b1; braddr_i[0] = 15'h0003;
        bce_i[1] = 1'b1; braddr_i[1] = 15'h0001;
        tick();
        bce_i[0] = 1'b0; bce_i[1] = 1'b0;
        n_cmp++;
        if (err_cnt !== EXP_ERR) begin
            n_mis++; $display("FAIL err_count: got %0d expected %0d", err_cnt, EXP_ERR);
        end
        tick();
        n_cmp++;
        if (v[1:0] !== 2'b11 || d[0] !== 64'h0000_0000_0000_00A0 || d[1] !== 64'h1111_0000_0000_0000) begin
            n_mis++; $display("FAIL err_wrapped_data: got v=%b d0=%h d1=%h expected v=11 d0=a0 d1=1111000000000000",
                              v[1:0], d[0], d[1]);
        end
        bce_i[2] = 1'b1; braddr_i[2] = 15'h0008;
        tick();
        bce_i[2] = 1'b0;
        n_cmp++;
        if (err_cnt !== EXP_ERR) begin
            n_mis++; $display("FAIL err_aligned_hold: got %0d expected %0d", err_cnt, EXP_ERR);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_read_priority();
        test_rd_after_wr();
        test_reset_mid();
        test_addr_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
